// File: rtl/svc_axi_router_rd.sv
// svc_axi_router_rd: AXI read-channel fan-out router, one manager to NUM_S
// subordinates. The upper address bits pick the subordinate; one burst is in
// flight at a time. Addresses that decode past NUM_S get a local DECERR burst.
module svc_axi_router_rd #(
    parameter int NUM_S          = 2,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int S_SEL_WIDTH    = $clog2(NUM_S)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    // manager side
    input  logic                                       s_axi_arvalid,
    output logic                                       s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]                    s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]                  s_axi_araddr,
    input  logic [7:0]                                 s_axi_arlen,
    input  logic [2:0]                                 s_axi_arsize,
    input  logic [1:0]                                 s_axi_arburst,
    output logic                                       s_axi_rvalid,
    output logic [AXI_ID_WIDTH-1:0]                    s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]                  s_axi_rdata,
    output logic [1:0]                                 s_axi_rresp,
    output logic                                       s_axi_rlast,
    input  logic                                       s_axi_rready,
    // subordinate side
    output logic [NUM_S-1:0]                           m_axi_arvalid,
    output logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]         m_axi_arid,
    output logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [NUM_S-1:0][7:0]                      m_axi_arlen,
    output logic [NUM_S-1:0][2:0]                      m_axi_arsize,
    output logic [NUM_S-1:0][1:0]                      m_axi_arburst,
    input  logic [NUM_S-1:0]                           m_axi_arready,
    input  logic [NUM_S-1:0]                           m_axi_rvalid,
    input  logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]         m_axi_rid,
    input  logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [NUM_S-1:0][1:0]                      m_axi_rresp,
    input  logic [NUM_S-1:0]                           m_axi_rlast,
    output logic [NUM_S-1:0]                           m_axi_rready
);

    // select register is at least one bit wide so NUM_S==1 still elaborates
    localparam int SW = (S_SEL_WIDTH > 0) ? S_SEL_WIDTH : 1;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_ERR} state_t;

    state_t                      r_state, w_next;
    logic                        r_arready;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                  r_len;
    logic [2:0]                  r_size;
    logic [1:0]                  r_burst;
    logic [SW-1:0]               r_sel;
    logic [7:0]                  r_cnt;
    logic [SW-1:0]               w_sel;
    logic                        w_sel_ok;
    logic                        w_ar_hs;

    generate
        if (NUM_S == 1) begin : g_sel_one
            assign w_sel = '0;
        end else begin : g_sel_dec
            assign w_sel = s_axi_araddr[AXI_ADDR_WIDTH-1 -: S_SEL_WIDTH];
        end
    endgenerate

    // a select field can encode more lanes than exist when NUM_S is not a power of 2
    assign w_sel_ok      = (32'(w_sel) < NUM_S);
    assign s_axi_arready = r_arready;
    assign w_ar_hs       = (r_state == S_IDLE) && s_axi_arvalid && r_arready;

    // AR fields come straight from the captured request on every lane; only
    // arvalid is steered, so the fields are stable for the whole AR phase
    genvar gi;
    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_lane
            assign m_axi_arid[gi]    = r_id;
            assign m_axi_araddr[gi]  = r_addr;
            assign m_axi_arlen[gi]   = r_len;
            assign m_axi_arsize[gi]  = r_size;
            assign m_axi_arburst[gi] = r_burst;
        end
    endgenerate

    // state, registered arready, request capture and DECERR beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_arready <= (w_next == S_IDLE);
            if (w_ar_hs) begin
                r_id    <= s_axi_arid;
                r_addr  <= s_axi_araddr;
                r_len   <= s_axi_arlen;
                r_size  <= s_axi_arsize;
                r_burst <= s_axi_arburst;
                r_sel   <= w_sel;
                r_cnt   <= s_axi_arlen;
            end else if (r_state == S_ERR && s_axi_rready && r_cnt != 8'd0) begin
                r_cnt   <= r_cnt - 8'd1;
            end
        end
    end

    // next state plus AR steering and the R mux / DECERR generator
    always_comb begin
        w_next        = r_state;
        m_axi_arvalid = '0;
        m_axi_rready  = '0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rlast   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) w_next = w_sel_ok ? S_AR : S_ERR;
            end
            S_AR: begin
                m_axi_arvalid[r_sel] = 1'b1;
                if (m_axi_arready[r_sel]) w_next = S_R;
            end
            S_R: begin
                s_axi_rvalid        = m_axi_rvalid[r_sel];
                s_axi_rid           = m_axi_rid[r_sel];
                s_axi_rdata         = m_axi_rdata[r_sel];
                s_axi_rresp         = m_axi_rresp[r_sel];
                s_axi_rlast         = m_axi_rlast[r_sel];
                m_axi_rready[r_sel] = s_axi_rready;
                if (m_axi_rvalid[r_sel] && s_axi_rready && m_axi_rlast[r_sel])
                    w_next = S_IDLE;
            end
            S_ERR: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = r_id;
                s_axi_rresp  = 2'b11;
                s_axi_rlast  = (r_cnt == 8'd0);
                if (s_axi_rready && r_cnt == 8'd0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_svc_axi_router_rd.sv
// tb_svc_axi_router_rd: directed bench for the read router. Two instances
// share stimulus: u2 (NUM_S=2) and u3 (NUM_S=3, which has an undecoded lane).
module tb_svc_axi_router_rd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cur3 = 1'b0;
    logic        s_arvalid = 1'b0;
    logic [3:0]  s_arid = '0;
    logic [7:0]  s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_rready = 1'b0;
    logic [2:0]        m_arready = '0;
    logic [2:0]        m_rvalid = '0;
    logic [2:0][3:0]   m_rid = '0;
    logic [2:0][15:0]  m_rdata = '0;
    logic [2:0][1:0]   m_rresp = '0;
    logic [2:0]        m_rlast = '0;

    // u2 outputs
    logic        a2_arready, a2_rvalid, a2_rlast;
    logic [3:0]  a2_rid;
    logic [15:0] a2_rdata;
    logic [1:0]  a2_rresp;
    logic [1:0]        a2_arvalid, a2_rready;
    logic [1:0][3:0]   a2_arid;
    logic [1:0][7:0]   a2_araddr, a2_arlen;
    logic [1:0][2:0]   a2_arsize;
    logic [1:0][1:0]   a2_arburst;
    // u3 outputs
    logic        a3_arready, a3_rvalid, a3_rlast;
    logic [3:0]  a3_rid;
    logic [15:0] a3_rdata;
    logic [1:0]  a3_rresp;
    logic [2:0]        a3_arvalid, a3_rready;
    logic [2:0][3:0]   a3_arid;
    logic [2:0][7:0]   a3_araddr, a3_arlen;
    logic [2:0][2:0]   a3_arsize;
    logic [2:0][1:0]   a3_arburst;

    svc_axi_router_rd #(.NUM_S(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arvalid(s_arvalid & ~cur3), .s_axi_arready(a2_arready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
        .s_axi_rvalid(a2_rvalid), .s_axi_rid(a2_rid), .s_axi_rdata(a2_rdata),
        .s_axi_rresp(a2_rresp), .s_axi_rlast(a2_rlast), .s_axi_rready(s_rready),
        .m_axi_arvalid(a2_arvalid), .m_axi_arid(a2_arid), .m_axi_araddr(a2_araddr),
        .m_axi_arlen(a2_arlen), .m_axi_arsize(a2_arsize), .m_axi_arburst(a2_arburst),
        .m_axi_arready(m_arready[1:0]), .m_axi_rvalid(m_rvalid[1:0]),
        .m_axi_rid(m_rid[1:0]), .m_axi_rdata(m_rdata[1:0]), .m_axi_rresp(m_rresp[1:0]),
        .m_axi_rlast(m_rlast[1:0]), .m_axi_rready(a2_rready)
    );

    svc_axi_router_rd #(.NUM_S(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arvalid(s_arvalid & cur3), .s_axi_arready(a3_arready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
        .s_axi_rvalid(a3_rvalid), .s_axi_rid(a3_rid), .s_axi_rdata(a3_rdata),
        .s_axi_rresp(a3_rresp), .s_axi_rlast(a3_rlast), .s_axi_rready(s_rready),
        .m_axi_arvalid(a3_arvalid), .m_axi_arid(a3_arid), .m_axi_araddr(a3_araddr),
        .m_axi_arlen(a3_arlen), .m_axi_arsize(a3_arsize), .m_axi_arburst(a3_arburst),
        .m_axi_arready(m_arready), .m_axi_rvalid(m_rvalid),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rready(a3_rready)
    );

    // view of whichever instance is under test
    logic        v_arready, v_rvalid, v_rlast;
    logic [3:0]  v_rid;
    logic [15:0] v_rdata;
    logic [1:0]  v_rresp;
    logic [2:0]        v_arvalid, v_rready;
    logic [2:0][3:0]   v_arid;
    logic [2:0][7:0]   v_araddr, v_arlen;
    assign v_arready = cur3 ? a3_arready : a2_arready;
    assign v_rvalid  = cur3 ? a3_rvalid  : a2_rvalid;
    assign v_rlast   = cur3 ? a3_rlast   : a2_rlast;
    assign v_rid     = cur3 ? a3_rid     : a2_rid;
    assign v_rdata   = cur3 ? a3_rdata   : a2_rdata;
    assign v_rresp   = cur3 ? a3_rresp   : a2_rresp;
    assign v_arvalid = cur3 ? a3_arvalid : {1'b0, a2_arvalid};
    assign v_rready  = cur3 ? a3_rready  : {1'b0, a2_rready};
    assign v_arid    = cur3 ? a3_arid    : {4'h0, a2_arid};
    assign v_araddr  = cur3 ? a3_araddr  : {8'h00, a2_araddr};
    assign v_arlen   = cur3 ? a3_arlen   : {8'h00, a2_arlen};

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        bit         use3;
        logic [7:0] addr;
        logic [3:0] id;
        logic [7:0] len;
        int         stall;   // cycles of arready=0 before the AR handshake
        bit         alt;     // manager rready toggles, starting low
        bit         stray;   // the other lane also offers a beat
        logic [1:0] sel;     // expected lane (3 = undecoded on u3)
        bit         err;     // expected DECERR burst
    } vec_t;

    vec_t tbl[7];

    // one full burst; returns early (signals still driven) once abort_after
    // beats have been accepted, otherwise ends at posedge+1 in IDLE
    task automatic run(input vec_t v, input int abort_after);
        int b, cyc;
        logic [2:0]  onehot;
        logic [1:0]  other;
        logic [15:0] exp_data;
        onehot = 3'b001 << v.sel;
        other  = v.sel ^ 2'd1;
        cur3      = v.use3;
        s_arvalid = 1'b1;
        s_araddr  = v.addr;
        s_arid    = v.id;
        s_arlen   = v.len;
        s_arsize  = 3'd1;
        s_arburst = 2'b01;
        @(negedge clk);
        chk("arready_idle", {31'd0, v_arready}, 32'd1);
        chk("arvalid_idle", {29'd0, v_arvalid}, 32'd0);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_araddr  = 8'h00;
        s_arid    = 4'h0;
        s_arlen   = 8'h00;
        if (!v.err) begin
            for (int c = 0; c <= v.stall; c++) begin
                if (c == v.stall) m_arready = onehot;
                @(negedge clk);
                chk("ar_arvalid", {29'd0, v_arvalid}, {29'd0, onehot});
                chk("ar_araddr", {24'd0, v_araddr[v.sel]}, {24'd0, v.addr});
                chk("ar_arlen", {24'd0, v_arlen[v.sel]}, {24'd0, v.len});
                chk("ar_arid", {28'd0, v_arid[v.sel]}, {28'd0, v.id});
                chk("ar_arready_low", {31'd0, v_arready}, 32'd0);
                chk("ar_rvalid_low", {31'd0, v_rvalid}, 32'd0);
                @(posedge clk); #1;
            end
            m_arready = '0;
        end
        b = 0;
        cyc = 0;
        while (b <= int'(v.len) && cyc < 200 && b != abort_after) begin
            if (!v.err) begin
                m_rvalid = onehot;
                m_rdata[v.sel] = 16'h00A0 + 16'(b);
                m_rid[v.sel]   = v.id;
                m_rresp[v.sel] = 2'b00;
                m_rlast        = (b == int'(v.len)) ? onehot : 3'b000;
                if (v.stray) begin
                    m_rvalid[other] = 1'b1;
                    m_rdata[other]  = 16'hDEAD;
                    m_rid[other]    = 4'hF;
                    m_rlast[other]  = 1'b1;
                end
            end
            s_rready = v.alt ? ((cyc % 2) == 1) : 1'b1;
            exp_data = v.err ? 16'h0000 : (16'h00A0 + 16'(b));
            @(negedge clk);
            chk("r_rvalid", {31'd0, v_rvalid}, 32'd1);
            chk("r_rdata", {16'd0, v_rdata}, {16'd0, exp_data});
            chk("r_rid", {28'd0, v_rid}, {28'd0, v.id});
            chk("r_rresp", {30'd0, v_rresp}, v.err ? 32'd3 : 32'd0);
            chk("r_rlast", {31'd0, v_rlast}, (b == int'(v.len)) ? 32'd1 : 32'd0);
            chk("r_sub_rready", {29'd0, v_rready}, s_rready ? {29'd0, onehot} : 32'd0);
            chk("r_arvalid_low", {29'd0, v_arvalid}, 32'd0);
            chk("r_arready_low", {31'd0, v_arready}, 32'd0);
            if (s_rready) b++;
            @(posedge clk); #1;
            cyc++;
        end
        if (abort_after >= 0) return;
        m_rvalid = '0;
        m_rlast  = '0;
        s_rready = 1'b0;
        chk("beat_count", b, int'(v.len) + 1);
        @(negedge clk);
        chk("post_arready", {31'd0, v_arready}, 32'd1);
        chk("post_rvalid", {31'd0, v_rvalid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        //          use3 addr   id   len  stall alt stray sel  err
        tbl[0] = '{1'b0, 8'h85, 4'h3, 8'd3, 0, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[1] = '{1'b0, 8'h10, 4'h7, 8'd0, 5, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 8'h40, 4'h1, 8'd7, 0, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 8'hF0, 4'h9, 8'd1, 0, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[4] = '{1'b1, 8'hC0, 4'h5, 8'd2, 0, 1'b1, 1'b0, 2'd3, 1'b1};
        tbl[5] = '{1'b1, 8'h80, 4'h2, 8'd1, 2, 1'b0, 1'b0, 2'd2, 1'b0};
        tbl[6] = '{1'b1, 8'h7F, 4'hA, 8'd0, 0, 1'b1, 1'b1, 2'd1, 1'b0};

        // reset values, then arready rises one edge after release
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur3 = (d == 1);
            #1;
            chk("rst_arready", {31'd0, v_arready}, 32'd0);
            chk("rst_arvalid", {29'd0, v_arvalid}, 32'd0);
            chk("rst_rvalid", {31'd0, v_rvalid}, 32'd0);
            chk("rst_araddr", {8'd0, v_araddr}, 32'd0);
        end
        cur3 = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_arready_low", {31'd0, v_arready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_arready_high", {31'd0, v_arready}, 32'd1);

        for (int i = 0; i < 7; i++) run(tbl[i], -1);

        // reset pulse after two of four beats
        run(tbl[0], 2);
        rst_n = 1'b0;
        #1;
        chk("mid_arready", {31'd0, v_arready}, 32'd0);
        chk("mid_arvalid", {29'd0, v_arvalid}, 32'd0);
        chk("mid_sub_rready", {29'd0, v_rready}, 32'd0);
        chk("mid_rvalid", {31'd0, v_rvalid}, 32'd0);
        chk("mid_rlast", {31'd0, v_rlast}, 32'd0);
        chk("mid_rdata", {16'd0, v_rdata}, 32'd0);
        chk("mid_rid", {28'd0, v_rid}, 32'd0);
        chk("mid_rresp", {30'd0, v_rresp}, 32'd0);
        chk("mid_araddr", {24'd0, v_araddr[1]}, 32'd0);
        chk("mid_arlen", {24'd0, v_arlen[1]}, 32'd0);
        m_rvalid = '0;
        m_rlast  = '0;
        s_rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_arready_low", {31'd0, v_arready}, 32'd0);
        chk("mid_rel_rvalid", {31'd0, v_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rel_arready_high", {31'd0, v_arready}, 32'd1);
        run(tbl[0], -1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/svc_axi_router_rd.md
# svc_axi_router_rd

Read-channel AXI router from one manager to NUM_S subordinates, the fan-out counterpart of the N-to-1 read arbiter. Each AR burst is steered to a subordinate chosen by the upper address bits, and that subordinate's R beats are returned until rlast. One burst is outstanding at a time. Addresses that decode to a non-existent subordinate get a locally generated DECERR burst. The block sits between an arbiter or manager and the memory/peripheral subordinates in the SVC AXI fabric.

## Interface
- NUM_S, 2: number of subordinates, ≥1
- AXI_ADDR_WIDTH, 8: address width
- AXI_DATA_WIDTH, 16: data width
- AXI_ID_WIDTH, 4: ID width, identical on both sides
- S_SEL_WIDTH, $clog2(NUM_S): select field width, derived
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_arvalid/arready  in/out  1  manager AR handshake
- s_axi_arid  in  AXI_ID_WIDTH  AR ID
- s_axi_araddr  in  AXI_ADDR_WIDTH  AR address
- s_axi_arlen  in  8  AR burst length
- s_axi_arsize  in  3  AR burst size
- s_axi_arburst  in  2  AR burst type
- s_axi_rvalid/rlast  out  1  R valid / last beat
- s_axi_rid  out  AXI_ID_WIDTH  R ID
- s_axi_rdata  out  AXI_DATA_WIDTH  R data
- s_axi_rresp  out  2  R response
- s_axi_rready  in  1  manager R ready
- m_axi_arvalid  out  [NUM_S]  per-subordinate AR valid
- m_axi_arid/araddr/arlen/arsize/arburst  out  [NUM_S][width as above]  AR fields, same value on all lanes
- m_axi_arready  in  [NUM_S]  per-subordinate AR ready
- m_axi_rvalid/rid/rdata/rresp/rlast  in  [NUM_S][width as above]  R fields
- m_axi_rready  out  [NUM_S]  per-subordinate R ready

## Operation
- Select: sel = araddr[AXI_ADDR_WIDTH-1 -: S_SEL_WIDTH]. If NUM_S==1, sel=0. The full address and ID are forwarded unmodified.
- FSM states: IDLE, AR, R, ERR.
- IDLE
  - s_axi_arready=1.
  - On the AR handshake, register id/addr/len/size/burst/sel.
  - Go to AR if sel<NUM_S, else ERR, with the beat counter loaded to arlen.
- AR
  - m_axi_arvalid[sel]=1; all other lanes 0.
  - Fields are driven from registers and held stable until m_axi_arready[sel].
  - On m_axi_arready[sel], go to R.
- R
  - Combinational pass-through: s_axi_r* = m_axi_r*[sel], m_axi_rready[sel]=s_axi_rready, other lanes' rready=0.
  - On s_axi_rvalid && s_axi_rready && s_axi_rlast, go to IDLE.
  - Beats from non-selected subordinates are never acknowledged.
- ERR
  - Drive s_axi_rvalid=1, rid=registered id, rdata=0, rresp=2'b11.
  - rlast=1 when counter==0.
  - Each handshake decrements the counter; the handshake with rlast returns to IDLE.
  - No m_axi_arvalid is asserted.
- s_axi_rvalid=0 in IDLE and AR; all R output fields are 0 when not in R/ERR.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - s_axi_arready=0 (registered); it rises on the first clk edge after rst_n deasserts.
  - m_axi_arvalid=0, m_axi_rready=0, s_axi_rvalid=0, s_axi_rlast=0, s_axi_rresp=0, s_axi_rid=0, s_axi_rdata=0.
  - m_axi_ar fields=0.
- s_axi_arready is registered as next_state==IDLE, so it drops the cycle after the accepting handshake.
- AR handshake at edge T → m_axi_arvalid[sel]=1 from cycle T+1. arvalid stays 1 with stable fields through any number of arready=0 cycles.
- R path adds zero cycles of latency: it is combinational in state R.
- The last-beat handshake at edge T → state=IDLE and s_axi_arready=1 in cycle T+1. Back-to-back bursts therefore cost ≥1 idle cycle.
- ERR: the first DECERR beat is valid at T+1 after the AR handshake. arlen+1 beats are produced, one per accepted handshake; s_axi_rready=0 stalls with outputs held.
- A reset mid-burst abandons the transaction. No partial beats are issued after rst_n rises.

## Test plan
- NUM_S=2, ARADDR=0x85, ARLEN=3, sub1 returns 4 beats (rdata 0xA0..0xA3):
  - m_axi_arvalid=2'b10, araddr=0x85.
  - 4 beats reach the manager with rid echoed; rlast on beat 4.
  - m_axi_rready[0]=0 throughout.
- Sub0 holds arready=0 for 5 cycles (ARADDR=0x10):
  - m_axi_arvalid[0]=1 with fields stable for all 5 cycles.
  - s_axi_arready=0 until the burst completes.
- NUM_S=3, ARADDR=0xC0, ARLEN=2, ARID=5:
  - No m_axi_arvalid.
  - 3 beats with rresp=2'b11, rid=5, rdata=0; rlast on the 3rd only.
- Manager drops rready on alternate cycles during an ARLEN=7 burst:
  - Exactly 8 beats are delivered in order; none lost or duplicated.
  - Sub rready mirrors s_axi_rready.
- Stray beat: sub0 asserts rvalid while routing to sub1 → m_axi_rready[0]=0 and the stray beat never reaches the manager.
- Reset pulse mid-burst (after beat 2 of 4):
  - All outputs return to reset values.
  - s_axi_arready=1 one cycle after release.
  - A new AR is accepted normally.
